// File: rtl/cmd_engine.sv
// Purpose : SD CMD-line engine; sends a 48-bit command with CRC7 and receives none/short/long responses with checks and retry.
// Latency : 48 SEND cycles, up to RESP_TIMEOUT wait cycles, 48/136 receive cycles plus one check cycle, then NCC gap cycles.
// Backpr. : no flow control; istart is taken only in IDLE, obusy high otherwise, odone pulses on the first IDLE cycle.
module cmd_engine #(
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_RETRIES  = 3,
  parameter int NCC          = 8,
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
  localparam int CMAX = (RESP_TIMEOUT > 136) ? RESP_TIMEOUT : 136,
  localparam int CW   = $clog2(CMAX)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          icmd_sd,
  output logic          ocmd_sd,
  input  logic          istart,
  input  logic [5:0]    icmd_index,
  input  logic [31:0]   icmd_arg,
  input  logic [1:0]    iresp_type,
  output logic [127:0]  oresp,
  output logic [5:0]    oresp_index,
  output logic          odone,
  output logic          obusy,
  output logic          oerr_timeout,
  output logic          oerr_crc,
  output logic          oerr_index,
  output logic [RW-1:0] oretry_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RCV  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // One CRC7 step, polynomial x^7+x^3+1, data bit shifted in MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // CRC7 over the 40 command header/argument bits.
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_index;
  logic [31:0]   r_arg;
  logic [1:0]    r_type;
  logic [127:0]  r_rx_sr;
  logic [6:0]    r_crc;
  logic          r_retry_pend;
  logic [RW-1:0] r_retry_cnt;
  logic [127:0]  r_resp;
  logic [5:0]    r_resp_index;
  logic          r_done;
  logic          r_err_timeout;
  logic          r_err_crc;
  logic          r_err_index;

  // Command frame is rebuilt from the latched fields, so a retry resends it unchanged.
  logic [39:0]   w_tx_payload;
  logic [47:0]   w_tx_frame;
  logic [5:0]    w_tx_idx;
  assign w_tx_payload = {2'b01, r_index, r_arg};
  assign w_tx_frame   = {w_tx_payload, crc7_40(w_tx_payload), 1'b1};
  assign w_tx_idx     = 6'd47 - r_cnt[5:0];

  // Receive bookkeeping: the start bit is taken in WAIT, so RCV shifts 47 or 135 more bits.
  // Only the low 128 bits are kept; a long frame's start/transmission/reserved bits fall off the top.
  logic          w_long;
  logic [CW-1:0] w_rx_nbits;
  logic [CW-1:0] w_crc_lo;
  logic [CW-1:0] w_crc_hi;
  logic          w_crc_en;
  logic          w_crc_bad;
  logic          w_idx_bad;
  logic          w_fail;
  logic [127:0]  w_rx_resp;
  logic [5:0]    w_rx_index;
  assign w_long     = (r_type == 2'b11);
  assign w_rx_nbits = w_long ? CW'(135) : CW'(47);
  assign w_crc_lo   = w_long ? CW'(7)   : CW'(0);
  assign w_crc_hi   = w_long ? CW'(126) : CW'(38);
  assign w_crc_en   = (r_cnt >= w_crc_lo) && (r_cnt <= w_crc_hi);
  // End-bit errors are reported through the CRC flag; R3 skips only the CRC compare.
  assign w_crc_bad  = ((r_type != 2'b10) && (r_crc != r_rx_sr[7:1])) || !r_rx_sr[0];
  assign w_idx_bad  = (r_type == 2'b01) && (r_rx_sr[45:40] != r_index);
  assign w_fail     = w_crc_bad || w_idx_bad;
  assign w_rx_resp  = w_long ? r_rx_sr : {96'd0, r_rx_sr[39:8]};
  assign w_rx_index = w_long ? 6'd0 : r_rx_sr[45:40];

  assign ocmd_sd      = (r_state == S_SEND) ? w_tx_frame[w_tx_idx] : 1'b1;
  assign obusy        = (r_state != S_IDLE);
  assign odone        = r_done;
  assign oresp        = r_resp;
  assign oresp_index  = r_resp_index;
  assign oerr_timeout = r_err_timeout;
  assign oerr_crc     = r_err_crc;
  assign oerr_index   = r_err_index;
  assign oretry_cnt   = r_retry_cnt;

  // Transaction sequencer: send, await start bit, receive, check/retry, inter-command gap.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_index       <= '0;
      r_arg         <= '0;
      r_type        <= '0;
      r_rx_sr       <= '0;
      r_crc         <= '0;
      r_retry_pend  <= 1'b0;
      r_retry_cnt   <= '0;
      r_resp        <= '0;
      r_resp_index  <= '0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_crc     <= 1'b0;
      r_err_index   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (istart) begin
            r_index       <= icmd_index;
            r_arg         <= icmd_arg;
            r_type        <= iresp_type;
            r_err_timeout <= 1'b0;
            r_err_crc     <= 1'b0;
            r_err_index   <= 1'b0;
            r_retry_cnt   <= '0;
            r_retry_pend  <= 1'b0;
            r_cnt         <= '0;
            r_state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_cnt == CW'(47)) begin
            r_cnt   <= '0;
            r_state <= (r_type == 2'b00) ? S_GAP : S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!icmd_sd) begin
            // Start bit is 0, so the CRC stays at its zero initial value.
            r_rx_sr <= '0;
            r_crc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RCV;
          end else if (r_cnt == CW'(RESP_TIMEOUT - 1)) begin
            r_err_timeout <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RCV: begin
          if (r_cnt != w_rx_nbits) begin
            r_rx_sr <= {r_rx_sr[126:0], icmd_sd};
            if (w_crc_en) r_crc <= crc7_step(r_crc, icmd_sd);
            r_cnt <= r_cnt + 1'b1;
          end else begin
            // Check cycle: whole frame is in r_rx_sr.
            r_cnt   <= '0;
            r_state <= S_GAP;
            if (!w_fail) begin
              r_resp       <= w_rx_resp;
              r_resp_index <= w_rx_index;
            end else if (r_retry_cnt < RW'(MAX_RETRIES)) begin
              r_retry_cnt  <= r_retry_cnt + 1'b1;
              r_retry_pend <= 1'b1;
            end else begin
              r_err_crc    <= w_crc_bad;
              r_err_index  <= w_idx_bad;
              r_resp       <= w_rx_resp;
              r_resp_index <= w_rx_index;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == CW'(NCC - 1)) begin
            r_cnt <= '0;
            if (r_retry_pend) begin
              r_retry_pend <= 1'b0;
              r_state      <= S_SEND;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_engine.sv
// Purpose : directed bench for cmd_engine with a card responder driving icmd_sd.
// Latency : checks exact CMD0 timing, response/retry/timeout outcomes and reset abort.
// Backpr. : none; every wait is bounded by a cycle budget.
module tb_cmd_engine;

  logic         iclk = 1'b0;
  logic         irst;
  logic         icmd_sd;
  logic         ocmd_sd;
  logic         istart;
  logic [5:0]   icmd_index;
  logic [31:0]  icmd_arg;
  logic [1:0]   iresp_type;
  logic [127:0] oresp;
  logic [5:0]   oresp_index;
  logic         odone;
  logic         obusy;
  logic         oerr_timeout;
  logic         oerr_crc;
  logic         oerr_index;
  logic [1:0]   oretry_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int busy_cnt  = 0;
  int done_cnt  = 0;
  int frame_cnt = 0;
  int cap_n     = 0;
  logic [47:0] cap;
  logic [47:0] last_frame;

  always #5 iclk = ~iclk;

  cmd_engine dut (
    .iclk         (iclk),
    .irst         (irst),
    .icmd_sd      (icmd_sd),
    .ocmd_sd      (ocmd_sd),
    .istart       (istart),
    .icmd_index   (icmd_index),
    .icmd_arg     (icmd_arg),
    .iresp_type   (iresp_type),
    .oresp        (oresp),
    .oresp_index  (oresp_index),
    .odone        (odone),
    .obusy        (obusy),
    .oerr_timeout (oerr_timeout),
    .oerr_crc     (oerr_crc),
    .oerr_index   (oerr_index),
    .oretry_cnt   (oretry_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC7 (x^7+x^3+1, init 0) over d[hi] down to d[lo].
  function automatic logic [6:0] crc7(input logic [135:0] d, input int hi, input int lo);
    logic [6:0] c;
    logic       inv;
    c = 7'd0;
    for (int i = hi; i >= lo; i--) begin
      inv = d[i] ^ c[6];
      c   = {c[5:0], 1'b0};
      if (inv) c = c ^ 7'b0001001;
    end
    return c;
  endfunction

  function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc);
    logic [135:0] f;
    f        = '0;
    f[47:0]  = {2'b00, idx, arg, 7'd0, 1'b1};
    f[7:1]   = crc7(f, 47, 8) ^ (bad_crc ? 7'h01 : 7'h00);
    return f;
  endfunction

  // Frame capture, busy/done counting, all on the falling edge.
  always @(negedge iclk) begin
    if (irst) begin
      cap_n <= 0;
    end else begin
      if (obusy) busy_cnt <= busy_cnt + 1;
      if (odone) done_cnt <= done_cnt + 1;
      if (cap_n == 0) begin
        if (obusy && !ocmd_sd) begin
          cap   <= 48'd0;
          cap_n <= 1;
        end
      end else begin
        cap <= {cap[46:0], ocmd_sd};
        if (cap_n == 47) begin
          last_frame <= {cap[46:0], ocmd_sd};
          frame_cnt  <= frame_cnt + 1;
          cap_n      <= 0;
        end else begin
          cap_n <= cap_n + 1;
        end
      end
    end
  end

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] ty);
    @(negedge iclk);
    icmd_index = idx;
    icmd_arg   = arg;
    iresp_type = ty;
    istart     = 1'b1;
    @(negedge iclk);
    istart     = 1'b0;
    icmd_index = ~idx;
    icmd_arg   = ~arg;
    iresp_type = ~ty;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frame_cnt < target && t < 3000) begin
      @(posedge iclk);
      t++;
    end
    if (frame_cnt < target) chk("frame_wait_timeout", 128'(frame_cnt), 128'(target));
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 3000) begin
      @(posedge iclk);
      t++;
    end
    if (done_cnt < target) chk("done_wait_timeout", 128'(done_cnt), 128'(target));
  endtask

  // Card side: idle-high for delay cycles, then nsend bits of an nbits frame MSB-first.
  task automatic card_send(input logic [135:0] fr, input int nbits, input int nsend, input int delay);
    repeat (delay) @(negedge iclk);
    for (int i = 0; i < nsend; i++) begin
      @(negedge iclk);
      icmd_sd = fr[nbits-1-i];
    end
    @(negedge iclk);
    icmd_sd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [47:0]  fr;
    logic [135:0] r;
    logic [135:0] l2;
    logic [119:0] cid;
    int busy_n, first_busy, done_at, f0, d0, b0;

    irst = 1'b1; istart = 1'b0; icmd_sd = 1'b1;
    icmd_index = '0; icmd_arg = '0; iresp_type = '0;
    #3;
    chk("rst_cmd_sd", 128'(ocmd_sd), 128'(1));
    chk("rst_busy", 128'(obusy), 128'(0));
    chk("rst_done", 128'(odone), 128'(0));
    chk("rst_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(0));
    chk("rst_resp", oresp, 128'(0));
    chk("rst_resp_index", 128'(oresp_index), 128'(0));
    chk("rst_retry", 128'(oretry_cnt), 128'(0));
    repeat (3) @(negedge iclk);
    irst = 1'b0;
    repeat (2) @(negedge iclk);

    // CMD0, no response, exact cycle timing
    @(negedge iclk);
    icmd_index = 6'd0; icmd_arg = 32'd0; iresp_type = 2'b00; istart = 1'b1;
    fr = '0; busy_n = 0; first_busy = -1; done_at = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge iclk);
      if (k == 1) istart = 1'b0;
      if (k <= 48) fr = {fr[46:0], ocmd_sd};
      if (obusy) begin
        busy_n++;
        if (first_busy < 0) first_busy = k;
      end
      if (odone && done_at < 0) done_at = k;
    end
    chk("cmd0_frame", 128'(fr), 128'(48'h40_0000_0000_95));
    chk("cmd0_busy_cycles", 128'(busy_n), 128'(56));
    chk("cmd0_busy_first", 128'(first_busy), 128'(1));
    chk("cmd0_done_cycle", 128'(done_at), 128'(57));
    chk("cmd0_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(0));

    // CMD8 with R7 echo
    f0 = frame_cnt; d0 = done_cnt;
    start_cmd(6'd8, 32'h0000_01AA, 2'b01);
    wait_frames(f0 + 1);
    card_send(mk_short(6'd8, 32'h0000_01AA, 1'b0), 48, 48, 5);
    wait_done(d0 + 1);
    chk("cmd8_hdr", 128'(last_frame[47:40]), 128'(8'h48));
    chk("cmd8_arg", 128'(last_frame[39:8]), 128'(32'h0000_01AA));
    chk("cmd8_crc", 128'(last_frame[7:1]), 128'(7'b1000011));
    chk("cmd8_resp", oresp, 128'(32'h0000_01AA));
    chk("cmd8_resp_index", 128'(oresp_index), 128'(8));
    chk("cmd8_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(0));
    chk("cmd8_retry", 128'(oretry_cnt), 128'(0));
    chk("cmd8_frames", 128'(frame_cnt - f0), 128'(1));

    // Bad CRC twice, then good
    f0 = frame_cnt; d0 = done_cnt;
    start_cmd(6'd55, 32'h1234_0000, 2'b01);
    for (int a = 0; a < 3; a++) begin
      wait_frames(f0 + a + 1);
      card_send(mk_short(6'd55, 32'h1234_0000, a < 2), 48, 48, 3);
    end
    wait_done(d0 + 1);
    chk("retry2_frames", 128'(frame_cnt - f0), 128'(3));
    chk("retry2_cnt", 128'(oretry_cnt), 128'(2));
    chk("retry2_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(0));
    chk("retry2_resp", oresp, 128'(32'h1234_0000));
    chk("retry2_last_arg", 128'(last_frame[39:8]), 128'(32'h1234_0000));

    // Bad CRC every attempt: retries exhausted
    f0 = frame_cnt; d0 = done_cnt;
    start_cmd(6'd13, 32'hABCD_0000, 2'b01);
    for (int a = 0; a < 4; a++) begin
      wait_frames(f0 + a + 1);
      card_send(mk_short(6'd13, 32'hABCD_0000, 1'b1), 48, 48, 3);
    end
    wait_done(d0 + 1);
    repeat (20) @(negedge iclk);
    chk("crcfail_frames", 128'(frame_cnt - f0), 128'(4));
    chk("crcfail_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(3'b010));
    chk("crcfail_retry", 128'(oretry_cnt), 128'(3));
    chk("crcfail_done_count", 128'(done_cnt - d0), 128'(1));
    chk("crcfail_resp", oresp, 128'(32'hABCD_0000));

    // Wrong index every attempt
    f0 = frame_cnt; d0 = done_cnt;
    start_cmd(6'd17, 32'h0000_0200, 2'b01);
    for (int a = 0; a < 4; a++) begin
      wait_frames(f0 + a + 1);
      card_send(mk_short(6'd18, 32'h0000_0200, 1'b0), 48, 48, 2);
    end
    wait_done(d0 + 1);
    chk("idxfail_frames", 128'(frame_cnt - f0), 128'(4));
    chk("idxfail_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(3'b001));
    chk("idxfail_retry", 128'(oretry_cnt), 128'(3));

    // R3: CRC and index fields are all ones and must not be checked
    f0 = frame_cnt; d0 = done_cnt;
    start_cmd(6'd41, 32'h40FF_8000, 2'b10);
    wait_frames(f0 + 1);
    r = '0;
    r[47:0] = {2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
    card_send(r, 48, 48, 6);
    wait_done(d0 + 1);
    chk("r3_resp", oresp, 128'(32'h80FF_8000));
    chk("r3_resp_index", 128'(oresp_index), 128'(6'h3F));
    chk("r3_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(0));
    chk("r3_retry", 128'(oretry_cnt), 128'(0));

    // Silent card: timeout, no retry
    f0 = frame_cnt; d0 = done_cnt; b0 = busy_cnt;
    start_cmd(6'd8, 32'h0000_01AA, 2'b01);
    wait_done(d0 + 1);
    chk("tmo_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(3'b100));
    chk("tmo_frames", 128'(frame_cnt - f0), 128'(1));
    chk("tmo_busy_cycles", 128'(busy_cnt - b0), 128'(48 + 64 + 8));
    chk("tmo_retry", 128'(oretry_cnt), 128'(0));

    // CMD2 with a long R2 response
    cid = 120'h112233445566778899AABBCCDDEEFF;
    l2 = {2'b00, 6'h3F, cid, 7'd0, 1'b1};
    l2[7:1] = crc7(l2, 127, 8);
    f0 = frame_cnt; d0 = done_cnt;
    start_cmd(6'd2, 32'd0, 2'b11);
    wait_frames(f0 + 1);
    card_send(l2, 136, 136, 4);
    wait_done(d0 + 1);
    chk("r2_resp", oresp, l2[127:0]);
    chk("r2_resp_index", 128'(oresp_index), 128'(0));
    chk("r2_flags", 128'({oerr_timeout, oerr_crc, oerr_index}), 128'(0));

    // CMD2 again, reset in the middle of the response
    f0 = frame_cnt; d0 = done_cnt;
    start_cmd(6'd2, 32'd0, 2'b11);
    wait_frames(f0 + 1);
    card_send(l2, 136, 20, 4);
    #2 irst = 1'b1;
    #1;
    chk("abort_cmd_sd", 128'(ocmd_sd), 128'(1));
    chk("abort_busy", 128'(obusy), 128'(0));
    chk("abort_resp", oresp, 128'(0));
    @(negedge iclk);
    irst = 1'b0;
    d0 = done_cnt;
    repeat (150) @(negedge iclk);
    chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
    chk("abort_idle", 128'(obusy), 128'(0));

    // Engine usable again after the abort
    d0 = done_cnt;
    start_cmd(6'd0, 32'd0, 2'b00);
    wait_done(d0 + 1);
    chk("post_rst_frame", 128'(last_frame), 128'(48'h40_0000_0000_95));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
